avalon_slave_regbank: RTL and testbench
=======================================

# avalon_slave_regbank

Generic Avalon-MM slave responder: a byte-enabled register bank with programmable read wait states, a `waitrequest` handshake and a doorbell-driven interrupt. It sits on the simulation Avalon bus opposite `avalon_master`, alongside compute slaves such as the divider. It gives the master a known-good target for exercising read wait states, write strobes and IRQ sequencing from an instruction table.

## Interface
- `ADDRESS_SIZE`, 3 — word-address bits; register count N = 2**ADDRESS_SIZE (minimum 2).
- `DATA_SIZE`, 32 — data width; must be a multiple of 8.
- `READ_WAIT`, 1 — read wait cycles, 0..15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `avs_chipselect`  in  1  slave select.
- `avs_read`  in  1  read request.
- `avs_write`  in  1  write request.
- `avs_address`  in  ADDRESS_SIZE  word address.
- `avs_byteenable`  in  DATA_SIZE/8  write byte lanes.
- `avs_writedata`  in  DATA_SIZE  write data.
- `avs_readdata`  out  DATA_SIZE  read data.
- `avs_waitrequest`  out  1  stall; the transfer completes in the first cycle where this is low.
- `avs_irq`  out  1  level interrupt.

## Operation
- Register map:
  - 0 = DOORBELL, R/W. A write to this register also sets `pending`.
  - 1..N-3 = general R/W.
  - N-2 = STATUS: bit0 = `pending`, write-1-to-clear on lane 0. Other bits read 0.
  - N-1 = CTRL: bit0 = `irq_en`, R/W. Other bits read 0.
- Reset values:
  - All registers, `pending` and `irq_en` reset to 0.
  - FSM resets to IDLE with the wait counter at 0.
  - Outputs under reset: `avs_readdata` = 0, `avs_waitrequest` = 0, `avs_irq` = 0.
- Writes: zero wait states. Committed at the rising edge where `avs_chipselect & avs_write`. Only lanes with `avs_byteenable` set are updated. `avs_waitrequest` stays 0.
- Read FSM:
  - IDLE: on `chipselect & read & ~write`, if READ_WAIT > 0, load cnt = READ_WAIT-1 and go to WAIT. If READ_WAIT = 0, the read completes in the same cycle.
  - WAIT: decrement cnt each cycle. When cnt = 0, go to DONE.
  - DONE: one cycle with `waitrequest` = 0 and data valid, then return to IDLE.
  - If `chipselect` or `read` drops while in WAIT or DONE, abort to IDLE with no side effects.
- `avs_waitrequest` = `chipselect & read & ~write & (READ_WAIT > 0) & (state != DONE)`.
- `avs_readdata` = combinational mux of the addressed register when `chipselect & read & ~waitrequest`, otherwise 0.
- Simultaneous `read` and `write`: the write is performed and the read is ignored. `waitrequest` = 0, `readdata` = 0.
- `avs_irq` = `pending & irq_en`, driven from registers with no combinational path from the bus.
- Unused address bits do not exist: every address decodes to a register.

## Timing
- Read latency: exactly READ_WAIT+1 cycles from request presentation to data capture by the master.
  - `waitrequest` is high for the first READ_WAIT cycles.
  - The master samples `readdata` at the rising edge ending the cycle where `waitrequest` is low.
- Back-to-back reads: each read re-enters IDLE for one cycle, so the next read costs another READ_WAIT+1 cycles.
- Write to DOORBELL at edge k: `pending` = 1 after edge k. `avs_irq` rises after edge k if `irq_en` = 1.
- Write of 1 to STATUS bit0 at edge k: `avs_irq` falls after edge k.
- DOORBELL set and STATUS clear cannot coincide, since there is one address per cycle.
- Enabling `irq_en` while `pending` = 1 raises `avs_irq` after that write's edge.
- Reset asserted mid-WAIT: all outputs go to 0 immediately (asynchronously). The FSM resumes in IDLE after release, and the master must re-issue the read.

## Configuration
- `AVSLAVE_IRQ_EN` defined:
  - STATUS, CTRL, `pending` and `avs_irq` are implemented as described above.
- `AVSLAVE_IRQ_EN` undefined:
  - No interrupt logic: `avs_irq` is tied to 0.
  - Registers N-2 and N-1 become general R/W registers.
  - DOORBELL is a plain register.

## Test plan
- Basic write/read (READ_WAIT=1): write 0x12345678 to reg 1 with BE=0xF, then read reg 1. Required: `waitrequest` high for 1 cycle, then `readdata` = 0x12345678 in the following cycle.
- Byte lanes: write 0xFFFFFFFF to reg 2, then write 0x000000AA with BE=0x1. Required: reg 2 reads 0xFFFFFFAA.
- Wait-state sweep: READ_WAIT = 0, 3, 15. Required: `waitrequest` high for exactly 0, 3, 15 cycles respectively, with correct data on the next cycle.
- IRQ flow (`AVSLAVE_IRQ_EN`):
  - Write CTRL = 1, then DOORBELL = 0x5. Required: `avs_irq` = 1 one edge later, and STATUS reads 0x1.
  - Write STATUS = 0x1. Required: `avs_irq` = 0 and STATUS reads 0.
- Aborts and reset:
  - Drop `chipselect` during WAIT. Required: `waitrequest` drops the same cycle and the FSM returns to IDLE.
  - Pulse `reset` during WAIT. Required: `readdata` = 0, `waitrequest` = 0, and all registers read 0 afterward.

Source files
------------

// File: rtl/avalon_slave_regbank_if.sv
// Avalon-MM slave bus bundle (everything except clk/reset), one modport per side.
interface avalon_slave_regbank_if #(
  parameter int ADDRESS_SIZE = 3,
  parameter int DATA_SIZE    = 32
);
  logic                      avs_chipselect;
  logic                      avs_read;
  logic                      avs_write;
  logic [ADDRESS_SIZE-1:0]   avs_address;
  logic [DATA_SIZE/8-1:0]    avs_byteenable;
  logic [DATA_SIZE-1:0]      avs_writedata;
  logic [DATA_SIZE-1:0]      avs_readdata;
  logic                      avs_waitrequest;
  logic                      avs_irq;

  modport master (
    output avs_chipselect, avs_read, avs_write, avs_address, avs_byteenable, avs_writedata,
    input  avs_readdata, avs_waitrequest, avs_irq
  );

  modport slave (
    input  avs_chipselect, avs_read, avs_write, avs_address, avs_byteenable, avs_writedata,
    output avs_readdata, avs_waitrequest, avs_irq
  );
endinterface

// File: rtl/avalon_slave_regbank.sv
// Byte-enabled Avalon-MM register bank: writes take 0 waits, reads stall READ_WAIT cycles on waitrequest.
// AVSLAVE_IRQ_EN adds DOORBELL->pending, STATUS (W1C) at N-2, CTRL irq_en at N-1 and a level irq.
module avalon_slave_regbank #(
  parameter int ADDRESS_SIZE = 3,
  parameter int DATA_SIZE    = 32,
  parameter int READ_WAIT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  avalon_slave_regbank_if.slave  avs
);
  localparam int         N        = 2 ** ADDRESS_SIZE;
  localparam int         LANES    = DATA_SIZE / 8;
  localparam bit         HAS_WAIT = (READ_WAIT > 0);
  localparam logic [3:0] CNT_LOAD = 4'(HAS_WAIT ? READ_WAIT - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;

  state_t               state, stateNext;
  logic [3:0]           cnt, cntNext;
  logic [DATA_SIZE-1:0] regs [N];
  logic [DATA_SIZE-1:0] readMux;
  logic [DATA_SIZE-1:0] writeMerged;
  logic                 readReq, writeReq, waitReq;

  assign readReq  = avs.avs_chipselect & avs.avs_read & ~avs.avs_write;
  assign writeReq = avs.avs_chipselect & avs.avs_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The count is tested after decrementing so waitrequest is high for exactly READ_WAIT cycles.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (readReq && HAS_WAIT) begin
          cntNext   = CNT_LOAD;
          stateNext = (CNT_LOAD == 4'd0) ? DONE : WAITING;
        end
      end
      WAITING: begin
        if (!readReq) begin
          stateNext = IDLE;
          cntNext   = 4'd0;
        end else begin
          cntNext = cnt - 4'd1;
          if (cntNext == 4'd0) stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
        cntNext   = 4'd0;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 4'd0;
      end
    endcase
  end

  assign waitReq             = ~reset & readReq & HAS_WAIT & (state != DONE);
  assign avs.avs_waitrequest = waitReq;

  always_comb begin
    writeMerged = regs[avs.avs_address];
    for (int b = 0; b < LANES; b++) begin
      if (avs.avs_byteenable[b]) writeMerged[8*b +: 8] = avs.avs_writedata[8*b +: 8];
    end
  end

`ifdef AVSLAVE_IRQ_EN
  localparam logic [ADDRESS_SIZE-1:0] ADDR_STATUS = ADDRESS_SIZE'(N - 2);
  localparam logic [ADDRESS_SIZE-1:0] ADDR_CTRL   = ADDRESS_SIZE'(N - 1);

  logic pending, irqEn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      pending <= 1'b0;
      irqEn   <= 1'b0;
    end else if (writeReq) begin
      if (avs.avs_address == ADDR_STATUS) begin
        if (avs.avs_byteenable[0] && avs.avs_writedata[0]) pending <= 1'b0;
      end else if (avs.avs_address == ADDR_CTRL) begin
        if (avs.avs_byteenable[0]) irqEn <= avs.avs_writedata[0];
      end else begin
        regs[avs.avs_address] <= writeMerged;
        if (avs.avs_address == '0) pending <= 1'b1;
      end
    end
  end

  always_comb begin
    readMux = regs[avs.avs_address];
    if (avs.avs_address == ADDR_STATUS)    readMux = {{(DATA_SIZE-1){1'b0}}, pending};
    else if (avs.avs_address == ADDR_CTRL) readMux = {{(DATA_SIZE-1){1'b0}}, irqEn};
  end

  // Both terms are flops, so the interrupt never glitches off the bus.
  assign avs.avs_irq = pending & irqEn;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (writeReq) begin
      regs[avs.avs_address] <= writeMerged;
    end
  end

  assign readMux     = regs[avs.avs_address];
  assign avs.avs_irq = 1'b0;
`endif

  assign avs.avs_readdata = (~reset & readReq & ~waitReq) ? readMux : '0;

endmodule

// File: tb/tb_avalon_slave_regbank.sv
// Four regbank instances (READ_WAIT = 1, 0, 3, 15) on a shared stimulus bus, checked against a
// register-map model; only the instance selected by sel sees chipselect.
module tb_avalon_slave_regbank;
  logic        clk = 1'b0;
  logic        rst;
  logic        cs, rd, wr;
  logic [2:0]  addr;
  logic [3:0]  be;
  logic [31:0] wd;
  int          sel;

  logic [31:0] rdatA [4];
  logic        wreqA [4];
  logic        irqA  [4];
  logic [31:0] rdat;
  logic        wreq, irq;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [4][8];
  bit          mPend [4];
  bit          mIrqEn [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    avalon_slave_regbank_if #(.ADDRESS_SIZE(3), .DATA_SIZE(32)) bus ();
    assign bus.avs_chipselect = cs && (sel == g);
    assign bus.avs_read       = rd;
    assign bus.avs_write      = wr;
    assign bus.avs_address    = addr;
    assign bus.avs_byteenable = be;
    assign bus.avs_writedata  = wd;
    assign rdatA[g] = bus.avs_readdata;
    assign wreqA[g] = bus.avs_waitrequest;
    assign irqA[g]  = bus.avs_irq;
    avalon_slave_regbank #(
      .ADDRESS_SIZE(3), .DATA_SIZE(32),
      .READ_WAIT((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15)
    ) dut (
      .clk(clk), .reset(rst), .avs(bus.slave)
    );
  end

  assign rdat = rdatA[sel];
  assign wreq = wreqA[sel];
  assign irq  = irqA[sel];

  function automatic int rw_of(input int s);
    case (s)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 15;
    endcase
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 8; a++) mem[s][a] = 32'h0;
      mPend[s]  = 1'b0;
      mIrqEn[s] = 1'b0;
    end
  endfunction

  function automatic void model_write(input int s, input int a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] mask;
    mask = 32'h0;
    for (int k = 0; k < 4; k++) if (b[k]) mask = mask | (32'hFF << (8 * k));
`ifdef AVSLAVE_IRQ_EN
    if (a == 6) begin
      if (b[0] && d[0]) mPend[s] = 1'b0;
      return;
    end
    if (a == 7) begin
      if (b[0]) mIrqEn[s] = d[0];
      return;
    end
    if (a == 0) mPend[s] = 1'b1;
`endif
    mem[s][a] = (mem[s][a] & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] exp_read(input int s, input int a);
`ifdef AVSLAVE_IRQ_EN
    if (a == 6) return {31'h0, mPend[s]};
    if (a == 7) return {31'h0, mIrqEn[s]};
`endif
    return mem[s][a];
  endfunction

  function automatic logic exp_irq(input int s);
`ifdef AVSLAVE_IRQ_EN
    return mPend[s] & mIrqEn[s];
`else
    return 1'b0 & s[0];
`endif
  endfunction

  task automatic do_write(input int s, input int a, input logic [3:0] b, input logic [31:0] d);
    sel = s; addr = 3'(a); be = b; wd = d; cs = 1'b1; wr = 1'b1; rd = 1'($urandom_range(0, 1));
    @(negedge clk);
    vectors++;
    if (wreq !== 1'b0 || rdat !== 32'h0) begin
      miscompares++;
      $display("FAIL write_bus dut%0d a%0d: waitrequest=%b readdata=%h, required 0/0", s, a, wreq, rdat);
    end
    @(posedge clk);
    model_write(s, a, b, d);
    #1;
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    vectors++;
    if (irq !== exp_irq(s)) begin
      miscompares++;
      $display("FAIL irq_after_write dut%0d a%0d: irq=%b, required %b", s, a, irq, exp_irq(s));
    end
  endtask

  task automatic do_read(input int s, input int a);
    int waits;
    bit done;
    logic [31:0] got;
    sel = s; addr = 3'(a); be = 4'($urandom); wd = $urandom; cs = 1'b1; rd = 1'b1; wr = 1'b0;
    waits = 0; done = 1'b0; got = 32'h0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (wreq === 1'b0) begin
        got  = rdat;
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL read_timeout dut%0d a%0d: waitrequest still high after %0d cycles, required low after %0d", s, a, waits, rw_of(s));
    end else begin
      vectors++;
      if (waits !== rw_of(s)) begin
        miscompares++;
        $display("FAIL read_waits dut%0d a%0d: %0d wait cycles, required %0d", s, a, waits, rw_of(s));
      end
      vectors++;
      if (got !== exp_read(s, a)) begin
        miscompares++;
        $display("FAIL read_data dut%0d a%0d: readdata=%h, required %h", s, a, got, exp_read(s, a));
      end
    end
  endtask

  task automatic test_reset();
    model_clear();
    rst = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 3'd0; be = 4'hF; wd = 32'h0;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #2;
      vectors++;
      if (wreq !== 1'b0 || rdat !== 32'h0 || irq !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: wr=%b rd=%h irq=%b, required 0/0/0", s, wreq, rdat, irq);
      end
    end
    cs = 1'b0; rd = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) do_read(0, a);
  endtask

  task automatic test_basic();
    do_write(0, 1, 4'hF, 32'h12345678);
    do_read(0, 1);
  endtask

  task automatic test_byte_lanes();
    do_write(0, 2, 4'hF, 32'hFFFFFFFF);
    do_write(0, 2, 4'h1, 32'h000000AA);
    do_read(0, 2);
    vectors++;
    if (mem[0][2] !== 32'hFFFFFFAA) begin
      miscompares++;
      $display("FAIL byte_lane_model: %h, required ffffffaa", mem[0][2]);
    end
  endtask

  task automatic test_wait_sweep();
    for (int s = 1; s < 4; s++) begin
      do_write(s, 3, 4'hF, 32'hC0DE0000 + s);
      do_read(s, 3);
    end
  endtask

  task automatic test_back_to_back();
    do_write(2, 4, 4'hF, 32'hA5A5A5A5);
    do_write(2, 5, 4'h6, 32'h11223344);
    do_read(2, 4);
    do_read(2, 5);
    do_read(2, 4);
  endtask

  task automatic test_irq();
`ifdef AVSLAVE_IRQ_EN
    do_write(0, 7, 4'h1, 32'h1);
    do_write(0, 0, 4'hF, 32'h5);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise: irq=%b, required 1", irq);
    end
    do_read(0, 6);
    do_write(0, 6, 4'h1, 32'h1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear: irq=%b, required 0", irq);
    end
    do_read(0, 6);
    do_write(0, 7, 4'h1, 32'h0);
    do_write(0, 0, 4'hF, 32'h6);
    do_write(0, 7, 4'hF, 32'h1);
    do_read(0, 7);
    do_write(0, 6, 4'h1, 32'h1);
`else
    do_write(0, 7, 4'hF, 32'h1);
    do_write(0, 0, 4'hF, 32'h5);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_tied: irq=%b, required 0", irq);
    end
    do_write(0, 6, 4'hF, 32'hDEADBEEF);
    do_read(0, 6);
    do_read(0, 7);
    do_read(0, 0);
`endif
  endtask

  task automatic test_abort();
    sel = 2; addr = 3'd3; cs = 1'b1; rd = 1'b1; wr = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (wreq !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_in_wait: waitrequest=%b, required 1", wreq);
    end
    cs = 1'b0;
    #1;
    vectors++;
    if (wreq !== 1'b0 || rdat !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_cs_drop: waitrequest=%b readdata=%h, required 0/0", wreq, rdat);
    end
    @(posedge clk); #1;
    do_read(2, 3);
    sel = 3; addr = 3'd1; cs = 1'b1; rd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rd = 1'b0;
    #1;
    vectors++;
    if (wreq !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_read_drop: waitrequest=%b, required 0", wreq);
    end
    @(posedge clk); #1;
    do_read(3, 3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 250; n++) begin
      int s, a;
      s = $urandom_range(0, 3);
      a = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) do_write(s, a, 4'($urandom), $urandom);
      else do_read(s, a);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_write(3, 2, 4'hF, 32'h0BADF00D);
    sel = 3; addr = 3'd2; cs = 1'b1; rd = 1'b1; wr = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (wreq !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_wait: waitrequest=%b, required 1", wreq);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (wreq !== 1'b0 || rdat !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: wr=%b rd=%h irq=%b, required 0/0/0", wreq, rdat, irq);
    end
    model_clear();
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) do_read(3, a);
    do_read(0, 1);
    do_read(2, 4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait_sweep();
    test_back_to_back();
    test_irq();
    test_abort();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
